// File: rtl/link_frame_rx.sv
// link_frame_rx
// Slave-side receiver for the link-port transport. Oversamples the SI line
// with the core clock, checks framing and even parity of each 43-bit frame
// (start, 40 payload bits LSB first, parity, stop), and presents the decoded
// pixel write and controller key word.
//
// Ports:
//   clk, reset_l          core clock, asynchronous active-low reset
//   enable                receiver enable (low forces idle, clears link state)
//   port_tran_si          raw asynchronous serial line, idles high
//   pixel_x_addr/_y_addr  last good frame X/Y address
//   pixel_shift           last good frame shift flag
//   pixel_brightness      last good frame brightness
//   cont_key              last good frame controller key word
//   frame_valid           one-cycle pulse, data outputs just updated
//   parity_err            one-cycle pulse, frame dropped on bad parity
//   framing_err           one-cycle pulse, frame dropped on low stop bit
//   link_active           a good frame was seen within LINK_TIMEOUT cycles
//
// State      | meaning
// -----------+--------------------------------------------------------
// IDLE       | waiting for a falling edge on the synchronized line
// START      | confirming the start bit at mid-bit
// DATA       | sampling the 40 payload bits
// PARITY     | sampling the parity bit
// STOP       | sampling the stop bit and committing / dropping the frame
// WAIT_HIGH  | after a framing error, waiting for the line to return high

module link_frame_rx #(
    parameter int CLKS_PER_BIT = 20,
    parameter int LINK_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        enable,
    input  logic        port_tran_si,
    output logic [9:0]  pixel_x_addr,
    output logic [9:0]  pixel_y_addr,
    output logic        pixel_shift,
    output logic [2:0]  pixel_brightness,
    output logic [15:0] cont_key,
    output logic        frame_valid,
    output logic        parity_err,
    output logic        framing_err,
    output logic        link_active
);

    localparam logic [7:0]  HALF       = 8'(CLKS_PER_BIT / 2);
    localparam logic [7:0]  LAST_PHASE = 8'(CLKS_PER_BIT - 1);
    localparam logic [19:0] TIMEOUT    = 20'(LINK_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t      state;
    logic        si_m;
    logic        si_s;
    logic        si_d;
    logic [7:0]  phase;
    logic [5:0]  bit_cnt;
    logic [39:0] shreg;
    logic        par_bit;
    logic [19:0] idle_cnt;

    logic        bit_sample;
    logic        parity_ok;
    logic        good_frame;

    // Synchronizer plus one extra stage for falling-edge detection.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            si_m <= 1'b1;
            si_s <= 1'b1;
            si_d <= 1'b1;
        end else begin
            si_m <= port_tran_si;
            si_s <= si_m;
            si_d <= si_s;
        end
    end

    assign bit_sample = (phase == LAST_PHASE);
    assign parity_ok  = ~(^shreg ^ par_bit);
    // Shared with the timeout logic so link_active rises together with frame_valid.
    assign good_frame = enable && (state == STOP) && bit_sample && si_s && parity_ok;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state            <= IDLE;
            phase            <= 8'd0;
            bit_cnt          <= 6'd0;
            shreg            <= 40'd0;
            par_bit          <= 1'b0;
            pixel_x_addr     <= 10'd0;
            pixel_y_addr     <= 10'd0;
            pixel_shift      <= 1'b0;
            pixel_brightness <= 3'd0;
            cont_key         <= 16'd0;
            frame_valid      <= 1'b0;
            parity_err       <= 1'b0;
            framing_err      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                phase   <= 8'd0;
                bit_cnt <= 6'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (si_d && !si_s) begin
                            state <= START;
                            phase <= 8'd0;
                        end
                    end
                    START: begin
                        if (phase == HALF) begin
                            phase   <= 8'd0;
                            bit_cnt <= 6'd0;
                            // A line already back high at mid start bit is a glitch.
                            state   <= si_s ? IDLE : DATA;
                        end else begin
                            phase <= phase + 8'd1;
                        end
                    end
                    DATA: begin
                        if (bit_sample) begin
                            phase <= 8'd0;
                            // Shift in at the top so the first bit ends up in bit 0.
                            shreg <= {si_s, shreg[39:1]};
                            if (bit_cnt == 6'd39) begin
                                state <= PARITY;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end else begin
                            phase <= phase + 8'd1;
                        end
                    end
                    PARITY: begin
                        if (bit_sample) begin
                            phase   <= 8'd0;
                            par_bit <= si_s;
                            state   <= STOP;
                        end else begin
                            phase <= phase + 8'd1;
                        end
                    end
                    STOP: begin
                        if (bit_sample) begin
                            phase <= 8'd0;
                            if (!si_s) begin
                                framing_err <= 1'b1;
                                state       <= WAIT_HIGH;
                            end else if (!parity_ok) begin
                                parity_err <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                pixel_x_addr     <= shreg[9:0];
                                pixel_y_addr     <= shreg[19:10];
                                pixel_shift      <= shreg[20];
                                pixel_brightness <= shreg[23:21];
                                cont_key         <= shreg[39:24];
                                frame_valid      <= 1'b1;
                                state            <= IDLE;
                            end
                        end else begin
                            phase <= phase + 8'd1;
                        end
                    end
                    WAIT_HIGH: begin
                        if (si_s) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Link supervision: saturating count of cycles since the last good frame.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            idle_cnt    <= 20'd0;
            link_active <= 1'b0;
        end else if (!enable) begin
            idle_cnt    <= 20'd0;
            link_active <= 1'b0;
        end else if (good_frame) begin
            idle_cnt    <= 20'd0;
            link_active <= 1'b1;
        end else if (idle_cnt != TIMEOUT) begin
            idle_cnt <= idle_cnt + 20'd1;
            if (idle_cnt + 20'd1 == TIMEOUT) begin
                link_active <= 1'b0;
            end
        end else begin
            link_active <= 1'b0;
        end
    end

endmodule

// File: tb/tb_link_frame_rx.sv
// Testbench for link_frame_rx: directed frames from the test plan followed by
// randomized good / bad-parity / bad-stop / glitch frames, all compared
// against a model that keeps the last good payload and expected pulse counts.

module tb_link_frame_rx;

    localparam int CPB = 20;
    localparam int LT  = 1000;

    logic        clk;
    logic        reset_l;
    logic        enable;
    logic        port_tran_si;
    logic [9:0]  pixel_x_addr;
    logic [9:0]  pixel_y_addr;
    logic        pixel_shift;
    logic [2:0]  pixel_brightness;
    logic [15:0] cont_key;
    logic        frame_valid;
    logic        parity_err;
    logic        framing_err;
    logic        link_active;

    link_frame_rx #(
        .CLKS_PER_BIT (CPB),
        .LINK_TIMEOUT (LT)
    ) dut (
        .clk              (clk),
        .reset_l          (reset_l),
        .enable           (enable),
        .port_tran_si     (port_tran_si),
        .pixel_x_addr     (pixel_x_addr),
        .pixel_y_addr     (pixel_y_addr),
        .pixel_shift      (pixel_shift),
        .pixel_brightness (pixel_brightness),
        .cont_key         (cont_key),
        .frame_valid      (frame_valid),
        .parity_err       (parity_err),
        .framing_err      (framing_err),
        .link_active      (link_active)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Cycles each pulse output was seen high.
    int n_fv = 0;
    int n_pe = 0;
    int n_fe = 0;

    always @(negedge clk) begin
        if (frame_valid) n_fv++;
        if (parity_err)  n_pe++;
        if (framing_err) n_fe++;
    end

    // Model state: last payload accepted and expected pulse totals.
    logic [39:0] exp_pl = 40'd0;
    int exp_fv = 0;
    int exp_pe = 0;
    int exp_fe = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [39:0] make_pl(input logic [9:0] x, input logic [9:0] y,
                                            input logic sh, input logic [2:0] br,
                                            input logic [15:0] key);
        return {key, br, sh, y, x};
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".x"},     64'(pixel_x_addr),     64'(exp_pl[9:0]));
        check_val({tag, ".y"},     64'(pixel_y_addr),     64'(exp_pl[19:10]));
        check_val({tag, ".shift"}, 64'(pixel_shift),      64'(exp_pl[20]));
        check_val({tag, ".bri"},   64'(pixel_brightness), 64'(exp_pl[23:21]));
        check_val({tag, ".key"},   64'(cont_key),         64'(exp_pl[39:24]));
        check_val({tag, ".n_fv"},  64'(n_fv), 64'(exp_fv));
        check_val({tag, ".n_pe"},  64'(n_pe), 64'(exp_pe));
        check_val({tag, ".n_fe"},  64'(n_fe), 64'(exp_fe));
    endtask

    // kind: 0 good, 1 parity flipped, 2 stop bit low (line then held low 100 cycles)
    task automatic send_frame(input logic [39:0] pl, input int kind);
        logic par;
        par = ^pl;
        if (kind == 1) par = ~par;
        port_tran_si = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 40; i++) begin
            port_tran_si = pl[i];
            wait_cyc(CPB);
        end
        port_tran_si = par;
        wait_cyc(CPB);
        port_tran_si = (kind == 2) ? 1'b0 : 1'b1;
        wait_cyc(CPB);
        if (kind == 2) begin
            wait_cyc(100);
        end
        port_tran_si = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [39:0] pl, input int kind);
        send_frame(pl, kind);
        wait_cyc(5);
        case (kind)
            0: begin
                exp_pl = pl;
                exp_fv++;
            end
            1: exp_pe++;
            default: exp_fe++;
        endcase
        check_outputs(tag);
        if (kind == 0) begin
            check_val({tag, ".link"}, 64'(link_active), 64'd1);
        end
    endtask

    task automatic glitch(input string tag);
        port_tran_si = 1'b0;
        wait_cyc(3);
        port_tran_si = 1'b1;
        wait_cyc(20);
        check_outputs(tag);
    endtask

    initial begin
        wait_cyc(200000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [39:0] pl;
        int kind;

        reset_l      = 1'b0;
        enable       = 1'b1;
        port_tran_si = 1'b1;
        wait_cyc(3);
        reset_l = 1'b1;

        // Reset state and idle line.
        wait_cyc(1000);
        check_outputs("reset");
        check_val("reset.link", 64'(link_active), 64'd0);

        // Directed frames.
        pl = make_pl(10'h155, 10'h2AA, 1'b1, 3'd5, 16'h8001);
        check_val("plan.parity_bit", 64'(^pl), 64'd1);
        run_frame("good1", pl, 0);
        run_frame("badpar", pl, 1);
        run_frame("badstop", make_pl(10'h3FF, 10'h0, 1'b0, 3'd7, 16'h1234), 2);
        run_frame("good2", make_pl(10'h001, 10'h0, 1'b0, 3'd0, 16'hFFFF), 0);
        glitch("glitch");
        run_frame("good3", make_pl(10'h2C3, 10'h11F, 1'b0, 3'd2, 16'h5A5A), 0);

        // Timeout: frame_valid was about 11 cycles before this point.
        wait_cyc(975);
        check_val("timeout.before", 64'(link_active), 64'd1);
        wait_cyc(30);
        check_val("timeout.after", 64'(link_active), 64'd0);

        // Enable dropped mid-frame: frame ignored, outputs held, link cleared.
        run_frame("pre_en", make_pl(10'h0AB, 10'h0CD, 1'b1, 3'd1, 16'hBEEF), 0);
        fork
            send_frame(make_pl(10'h3C3, 10'h3C3, 1'b0, 3'd6, 16'h0F0F), 0);
            begin
                wait_cyc(300);
                enable = 1'b0;
            end
        join
        wait_cyc(50);
        check_outputs("disabled");
        check_val("disabled.link", 64'(link_active), 64'd0);
        enable = 1'b1;
        wait_cyc(5);
        run_frame("reenable", make_pl(10'h123, 10'h321, 1'b1, 3'd4, 16'hC0DE), 0);

        // Randomized frames with random inter-frame gaps (including none).
        for (int n = 0; n < 24; n++) begin
            pl   = {8'($urandom), 32'($urandom)};
            kind = int'($urandom_range(0, 3));
            if (kind == 3) glitch("rnd.glitch");
            else           run_frame("rnd", pl, kind);
            wait_cyc(int'($urandom_range(0, 8)));
        end

        // Back-to-back good frames with no idle between stop and next start.
        send_frame(make_pl(10'h2F0, 10'h00F, 1'b1, 3'd3, 16'h7777), 0);
        exp_fv++;
        run_frame("b2b", make_pl(10'h10F, 10'h3E0, 1'b0, 3'd5, 16'h9999), 0);
        exp_pl = make_pl(10'h10F, 10'h3E0, 1'b0, 3'd5, 16'h9999);
        check_outputs("b2b.final");

        // Reset mid-frame: no pulse, everything back to reset values.
        fork
            send_frame(make_pl(10'h3AA, 10'h155, 1'b1, 3'd7, 16'hAAAA), 0);
            begin
                wait_cyc(400);
                reset_l = 1'b0;
            end
        join
        wait_cyc(3);
        exp_pl = 40'd0;
        check_outputs("midreset");
        check_val("midreset.link", 64'(link_active), 64'd0);
        reset_l = 1'b1;
        wait_cyc(20);
        check_outputs("post_reset");
        run_frame("final", make_pl(10'h055, 10'h0AA, 1'b0, 3'd2, 16'h4321), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
